// File: rtl/mips_core_pkg.sv
// Shared core definitions: memory access kinds and data-cache geometry/FSM encoding.
package mips_core_pkg;

  localparam int DC_INDEX_BITS  = 4;
  localparam int DC_OFFSET_BITS = 2;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } MemAccessType;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REFILL_REQ  = 2'd1,
    REFILL_WAIT = 2'd2
  } dc_state_t;

endpackage

// File: rtl/dc_tag_data_array.sv
// Valid/tag/data storage for the direct-mapped data cache; combinational read, registered writes.
module dc_tag_data_array
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS  = DC_INDEX_BITS,
  parameter int OFFSET_BITS = DC_OFFSET_BITS,
  parameter int CTAG_W      = 24,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [CTAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   beat_en,
  input  logic [INDEX_BITS-1:0]  beat_index,
  input  logic [OFFSET_BITS-1:0] beat_offset,
  input  logic [DATA_WIDTH-1:0]  beat_data,
  input  logic                   set_en,
  input  logic [INDEX_BITS-1:0]  set_index,
  input  logic [CTAG_W-1:0]      set_tag,
  input  logic                   clr_en,
  input  logic [INDEX_BITS-1:0]  clr_index
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  logic [LINES-1:0]      valid_q;
  logic [CTAG_W-1:0]     tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES][WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_index] <= 1'b0;
      if (set_en) valid_q[set_index] <= 1'b1;
    end
  end

  // Tag and data contents are only meaningful behind a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en)   data_q[wr_index][wr_offset]     <= wr_data;
    if (beat_en) data_q[beat_index][beat_offset] <= beat_data;
    if (set_en)  tag_q[set_index]                <= set_tag;
  end

endmodule

// File: rtl/d_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache answering the reservation-station request channel.
module d_cache_responder
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 4,
  parameter int INDEX_BITS  = DC_INDEX_BITS,
  parameter int OFFSET_BITS = DC_OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  flush,
  output logic                  req_stall,
  output logic                  ld_done_valid,
  output logic [TAG_WIDTH-1:0]  ld_done_tag,
  output logic [DATA_WIDTH-1:0] ld_done_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data
);

  localparam int CTAG_W = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;

  dc_state_t              state, state_d;
  logic [OFFSET_BITS-1:0] beat_cnt;
  logic [INDEX_BITS-1:0]  fill_index;
  logic [CTAG_W-1:0]      fill_tag;

  MemAccessType           req_kind;
  logic [OFFSET_BITS-1:0] addr_offset;
  logic [INDEX_BITS-1:0]  addr_index;
  logic [CTAG_W-1:0]      addr_tag;
  logic                   rd_valid;
  logic [CTAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   hit, load_hit, store_hit_wr, beat_en, last_beat, clr_en;

  assign req_kind    = MemAccessType'(req_write);
  assign addr_offset = req_addr[OFFSET_BITS+1:2];
  assign addr_index  = req_addr[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign addr_tag    = req_addr[ADDR_WIDTH-1:INDEX_BITS+OFFSET_BITS+2];

  assign hit          = rd_valid && (rd_tag == addr_tag);
  assign load_hit     = (state == IDLE) && req_valid && (req_kind == READ) && hit;
  assign store_hit_wr = (state == IDLE) && req_valid && (req_kind == WRITE) && mem_req_ready && hit;
  assign beat_en      = (state == REFILL_WAIT) && mem_rsp_valid;
  assign last_beat    = beat_en && (beat_cnt == '1);
  assign clr_en       = (state == REFILL_REQ) && mem_req_ready;

  dc_tag_data_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .CTAG_W     (CTAG_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_index   (addr_index),
    .rd_offset  (addr_offset),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (store_hit_wr),
    .wr_index   (addr_index),
    .wr_offset  (addr_offset),
    .wr_data    (req_data),
    .beat_en    (beat_en),
    .beat_index (fill_index),
    .beat_offset(beat_cnt),
    .beat_data  (mem_rsp_data),
    .set_en     (last_beat),
    .set_index  (fill_index),
    .set_tag    (fill_tag),
    .clr_en     (clr_en),
    .clr_index  (fill_index)
  );

  always_comb begin
    state_d       = state;
    req_stall     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    case (state)
      IDLE: begin
        if (req_valid && (req_kind == WRITE)) begin
          mem_req_valid = 1'b1;
          mem_req_write = 1'b1;
          mem_req_addr  = req_addr;
          mem_req_data  = req_data;
          req_stall     = !mem_req_ready;
        end else if (req_valid && !hit) begin
          req_stall = 1'b1;
          state_d   = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {fill_tag, fill_index, {(OFFSET_BITS+2){1'b0}}};
        req_stall     = 1'b1;
        if (mem_req_ready) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        req_stall = 1'b1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      ld_done_valid <= 1'b0;
      ld_done_tag   <= '0;
      ld_done_data  <= '0;
    end else begin
      state         <= state_d;
      ld_done_valid <= load_hit && !flush;
      if (beat_en) beat_cnt <= beat_cnt + 1'b1;
      if (load_hit) begin
        ld_done_tag  <= req_tag;
        ld_done_data <= rd_data;
      end
    end
  end

  // The miss line is captured from the held request so a flushed, dropped request cannot redirect the refill.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && (state_d == REFILL_REQ)) begin
      fill_index <= addr_index;
      fill_tag   <= addr_tag;
    end
  end

endmodule

// File: tb/tb_d_cache_responder.sv
// Directed self-checking bench for d_cache_responder: refill, hits, write-through stores, flush and mid-refill reset.
module tb_d_cache_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, flush;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_tag;
  logic        req_stall, ld_done_valid;
  logic [3:0]  ld_done_tag;
  logic [31:0] ld_done_data;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  d_cache_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_tag      (req_tag),
    .flush        (flush),
    .req_stall    (req_stall),
    .ld_done_valid(ld_done_valid),
    .ld_done_tag  (ld_done_tag),
    .ld_done_data (ld_done_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write),
    .mem_req_addr (mem_req_addr),
    .mem_req_data (mem_req_data),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic load_hit(input logic [31:0] addr, input logic [3:0] tag, input logic [31:0] exp);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_tag = tag;
    #1;
    check("hit_stall", 32'(req_stall), 32'd0);
    check("hit_no_mem", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    check("hit_done_valid", 32'(ld_done_valid), 32'd1);
    check("hit_done_tag", 32'(ld_done_tag), 32'(tag));
    check("hit_done_data", ld_done_data, exp);
    req_valid = 1'b0;
  endtask

  task automatic load_miss(input logic [31:0] addr, input logic [3:0] tag, input logic [31:0] base);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_tag = tag;
    #1;
    check("miss_stall", 32'(req_stall), 32'd1);
    check("miss_no_mem_idle", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    check("refill_req_valid", 32'(mem_req_valid), 32'd1);
    check("refill_req_write", 32'(mem_req_write), 32'd0);
    check("refill_req_addr", mem_req_addr, {addr[31:4], 4'h0});
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("refill_wait_no_req", 32'(mem_req_valid), 32'd0);
    check("refill_wait_stall", 32'(req_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = base + 32'(i);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    #1;
    check("refill_done_stall", 32'(req_stall), 32'd0);
    check("refill_done_pending", 32'(ld_done_valid), 32'd0);
    @(negedge clk);
    check("miss_done_valid", 32'(ld_done_valid), 32'd1);
    check("miss_done_tag", 32'(ld_done_tag), 32'(tag));
    check("miss_done_data", ld_done_data, base + 32'(addr[3:2]));
    req_valid = 1'b0;
    @(negedge clk);
    check("miss_done_pulse", 32'(ld_done_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    req_tag = '0; flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_stall", 32'(req_stall), 32'd0);
    check("rst_done_valid", 32'(ld_done_valid), 32'd0);
    check("rst_done_tag", 32'(ld_done_tag), 32'd0);
    check("rst_done_data", ld_done_data, 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_addr", mem_req_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss and refill, then hit on another word of the line
    load_miss(32'h100, 4'd3, 32'hA0);
    load_hit(32'h108, 4'd5, 32'hA2);

    // Write-through store hit with two cycles of backpressure
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h104; req_data = 32'hDEAD;
    #1;
    check("st_stall_1", 32'(req_stall), 32'd1);
    check("st_mem_valid", 32'(mem_req_valid), 32'd1);
    check("st_mem_write", 32'(mem_req_write), 32'd1);
    check("st_mem_addr", mem_req_addr, 32'h104);
    check("st_mem_data", mem_req_data, 32'hDEAD);
    @(negedge clk); #1;
    check("st_stall_2", 32'(req_stall), 32'd1);
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    check("st_accept_stall", 32'(req_stall), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; mem_req_ready = 1'b0;
    load_hit(32'h104, 4'd6, 32'hDEAD);

    // Store miss goes to memory without allocating
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h500; req_data = 32'h55; mem_req_ready = 1'b1;
    #1;
    check("stm_mem_valid", 32'(mem_req_valid), 32'd1);
    check("stm_mem_addr", mem_req_addr, 32'h500);
    check("stm_stall", 32'(req_stall), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; mem_req_ready = 1'b0;
    load_miss(32'h500, 4'd7, 32'hB0);

    // Flush during refill: line still installed, no result
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h200; req_tag = 4'd8;
    @(negedge clk);
    check("fl_req_addr", mem_req_addr, 32'h200);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; flush = 1'b1; req_valid = 1'b0; req_addr = 32'hFFF0;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hC0 + 32'(i);
      @(negedge clk);
      check("fl_no_done", 32'(ld_done_valid), 32'd0);
    end
    mem_rsp_valid = 1'b0;
    #1;
    check("fl_idle_stall", 32'(req_stall), 32'd0);
    @(negedge clk);
    check("fl_no_done_after", 32'(ld_done_valid), 32'd0);
    load_hit(32'h20C, 4'd9, 32'hC3);

    // Flush suppresses a hit sampled in the same cycle
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h208; req_tag = 4'd12; flush = 1'b1;
    @(negedge clk);
    check("fl_hit_suppressed", 32'(ld_done_valid), 32'd0);
    req_valid = 1'b0; flush = 1'b0;

    // Reset after two refill beats
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h300; req_tag = 4'd10;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hD0 + 32'(i);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0; req_valid = 1'b0; rst_n = 1'b0;
    #1;
    check("mrst_stall", 32'(req_stall), 32'd0);
    check("mrst_mem_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_miss(32'h300, 4'd11, 32'hE0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
